// File: rtl/audio_pkg.sv
// Shared audio constants used by the output stage and the playback stage.
//   GAIN_MAX   : full-scale gain of the mute/unmute ramp (unity)
//   GAIN_SHIFT : right shift that normalises sample x gain back to sample range
//   PDM_MID    : modulator level for a zero-valued sample (50 % ones density)
//   AUDIO_W    : width of a signed audio sample
package audio_pkg;

  localparam int GAIN_MAX   = 16;
  localparam int GAIN_SHIFT = 4;
  localparam int PDM_MID    = 128;
  localparam int AUDIO_W    = 8;

  // Gain must hold 0..GAIN_MAX inclusive.
  localparam int GAIN_W     = $clog2(GAIN_MAX + 1);

endpackage

// File: rtl/pdm_modulator.sv
// First-order sigma-delta modulator: converts an unsigned 8-bit level into a
// 1-bit stream whose ones density is level/256.
// Ports:
//   clk_in   : system clock, posedge
//   rst_in   : synchronous active-low reset
//   level_in : unsigned level 0..255
//   pdm_out  : 1-bit stream; any 256 consecutive bits hold exactly level ones
module pdm_modulator (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] level_in,
  output logic       pdm_out
);

  logic [8:0] acc;
  logic [8:0] sum;

  // Only the low 8 bits carry the running error; bit 8 of the new sum is the
  // overflow that becomes the output bit.
  assign sum = {1'b0, acc[7:0]} + {1'b0, level_in};

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      acc <= '0;
    end else begin
      acc <= sum;
    end
  end

  // acc[8] is the registered overflow of the last sum, i.e. the output bit.
  assign pdm_out = acc[8];

endmodule

// File: rtl/audio_pdm_out.sv
// Audio output stage: sample-rate divider, sample latch, click-free gain ramp,
// shift-based volume and sigma-delta output.
// Ports:
//   clk_in          : system clock, posedge
//   rst_in          : synchronous active-low reset
//   audio_in        : signed sample, latched on tick cycles
//   volume_in       : attenuation as arithmetic right shift 0..7
//   mute_in         : 1 ramps gain to 0, 0 ramps gain to full
//   sample_tick_out : one-cycle strobe per sample period
//   pdm_out         : 1-bit sigma-delta stream to the audio pin
//   active_out      : 1 while gain is non-zero
module audio_pdm_out
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = 8333
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [AUDIO_W-1:0] audio_in,
  input  logic [2:0]         volume_in,
  input  logic               mute_in,
  output logic               sample_tick_out,
  output logic               pdm_out,
  output logic               active_out
);

  localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PROD_W = AUDIO_W + GAIN_W;

  logic [CNT_W-1:0]          counter;
  logic                      vld_p1;
  logic signed [AUDIO_W-1:0] sample_reg;
  logic [GAIN_W-1:0]         gain;
  logic [GAIN_W-1:0]         gain_nxt;
  logic [7:0]                level_reg;

  // One ramp step toward the target; holds once the target is reached.
  function automatic logic [GAIN_W-1:0] step_gain(input logic [GAIN_W-1:0] g,
                                                  input logic mute);
    if (mute) begin
      return (g != '0) ? g - 1'b1 : g;
    end
    return (g != GAIN_W'(GAIN_MAX)) ? g + 1'b1 : g;
  endfunction

  // sample x gain, normalised and attenuated with arithmetic shifts (floor
  // rounding), then offset to the unsigned modulator range. |scaled| <= 128
  // so the 8-bit result never wraps.
  function automatic logic [7:0] calc_level(input logic signed [AUDIO_W-1:0] s,
                                            input logic [GAIN_W-1:0] g,
                                            input logic [2:0] vol);
    logic signed [PROD_W-1:0] s_ext;
    logic signed [PROD_W-1:0] g_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] scaled;
    s_ext  = {{GAIN_W{s[AUDIO_W-1]}}, s};
    g_ext  = {{AUDIO_W{1'b0}}, g};
    prod   = s_ext * g_ext;
    scaled = (prod >>> GAIN_SHIFT) >>> vol;
    return 8'(scaled + PROD_W'(PDM_MID));
  endfunction

  assign gain_nxt = step_gain(gain, mute_in);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      counter         <= '0;
      sample_tick_out <= 1'b0;
      vld_p1          <= 1'b0;
      sample_reg      <= '0;
      gain            <= '0;
      active_out      <= 1'b0;
      level_reg       <= 8'(PDM_MID);
    end else begin
      // p0: divider and tick strobe
      sample_tick_out <= (counter == CNT_W'(SAMPLE_DIV - 1));
      counter         <= (counter == CNT_W'(SAMPLE_DIV - 1)) ? '0 : counter + 1'b1;
      vld_p1          <= sample_tick_out;
      if (sample_tick_out) begin
        sample_reg <= audio_in;
        gain       <= gain_nxt;
        active_out <= (gain_nxt != '0);
      end
      // p1: level calculation in the cycle after a tick
      if (vld_p1) begin
        level_reg <= calc_level(sample_reg, gain, volume_in);
      end
    end
  end

  // p2: sigma-delta modulator
  pdm_modulator u_mod (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .level_in (level_reg),
    .pdm_out  (pdm_out)
  );

endmodule

// File: tb/tb_audio_pdm_out.sv
module tb_audio_pdm_out;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic signed [7:0] audio_in = '0;
  logic [2:0]        volume_in = '0;
  logic              mute_in = 1'b0;
  logic              sample_tick_out;
  logic              pdm_out;
  logic              active_out;

  int passed = 0;
  int total  = 0;
  int mgain  = 0;   // reference gain 0..16
  int msample = 0;  // reference latched sample

  typedef struct {
    logic signed [7:0] audio;
    logic [2:0]        vol;
    int                level;
    int                ones;   // -1: no window count
  } vec_t;

  audio_pdm_out #(.SAMPLE_DIV(4)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .audio_in        (audio_in),
    .volume_in       (volume_in),
    .mute_in         (mute_in),
    .sample_tick_out (sample_tick_out),
    .pdm_out         (pdm_out),
    .active_out      (active_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // floor division, b > 0
  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int ref_level(input int s, input int g, input int v);
    return fdiv(fdiv(s * g, 16), 1 << v) + 128;
  endfunction

  task automatic garbage();
    audio_in  = 8'($urandom);
    mute_in   = 1'($urandom);
    volume_in = 3'($urandom);
  endtask

  // Hold reset for a few cycles (no ticks allowed), then release at a negedge.
  task automatic reset_dut();
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      garbage();
      @(negedge clk_in);
      check("tick_in_reset", int'(sample_tick_out), 0);
    end
    rst_in  = 1'b1;
    mgain   = 0;
    msample = 0;
  endtask

  // One sample period: present a/m on the tick cycle, v in the level-calc
  // cycle, garbage elsewhere; compare gain/active and the resulting level.
  task automatic do_period(input logic signed [7:0] a, input logic m,
                           input logic [2:0] v);
    int waited;
    waited = 0;
    @(negedge clk_in);
    while (sample_tick_out !== 1'b1 && waited < 16) begin
      garbage();
      @(negedge clk_in);
      waited++;
    end
    check("tick_seen", int'(sample_tick_out === 1'b1), 1);
    if (sample_tick_out !== 1'b1) return;
    audio_in  = a;
    mute_in   = m;
    volume_in = 3'($urandom);
    if (m) begin
      if (mgain > 0) mgain--;
    end else begin
      if (mgain < 16) mgain++;
    end
    msample = int'(a);
    @(negedge clk_in);
    volume_in = v;
    audio_in  = 8'($urandom);
    mute_in   = 1'($urandom);
    check("gain", int'(dut.gain), mgain);
    check("active", int'(active_out), int'(mgain != 0));
    @(negedge clk_in);
    check("level", int'(dut.level_reg), ref_level(msample, mgain, int'(v)));
    audio_in  = a;
    mute_in   = m;
    volume_in = v;
  endtask

  task automatic count_ones(output int n);
    n = 0;
    repeat (256) begin
      @(negedge clk_in);
      n += int'(pdm_out);
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   n;
    int   exp_lvl;

    vecs[0] = '{audio: -8'sd128, vol: 3'd3, level: 112, ones: -1};
    vecs[1] = '{audio: -8'sd1,   vol: 3'd3, level: 127, ones: -1};
    vecs[2] = '{audio: 8'sd127,  vol: 3'd3, level: 143, ones: -1};
    vecs[3] = '{audio: 8'sd127,  vol: 3'd0, level: 255, ones: 255};
    vecs[4] = '{audio: -8'sd128, vol: 3'd0, level: 0,   ones: 0};
    vecs[5] = '{audio: 8'sd64,   vol: 3'd2, level: 144, ones: -1};
    vecs[6] = '{audio: -8'sd1,   vol: 3'd0, level: 127, ones: 127};
    vecs[7] = '{audio: -8'sd3,   vol: 3'd1, level: 126, ones: -1};

    // Reset state and tick spacing
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
    check("rst_level", int'(dut.level_reg), 128);
    check("rst_gain", int'(dut.gain), 0);
    check("rst_acc", int'(dut.u_mod.acc), 0);
    check("rst_pdm", int'(pdm_out), 0);
    check("rst_active", int'(active_out), 0);
    check("rst_tick", int'(sample_tick_out), 0);
    reset_dut();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_in);
      check($sformatf("tick_c%0d", c), int'(sample_tick_out), int'(c % 4 == 0));
    end

    // Ramp up with +64
    reset_dut();
    for (int k = 1; k <= 20; k++) begin
      do_period(8'sd64, 1'b0, 3'd0);
      check($sformatf("ramp_k%0d", k), int'(dut.level_reg), 128 + 4 * ((k < 16) ? k : 16));
    end
    count_ones(n);
    check("ramp_window_ones", n, 192);

    // Mute ramp down
    for (int k = 1; k <= 16; k++) begin
      do_period(8'sd64, 1'b1, 3'd0);
      check($sformatf("mute_k%0d", k), int'(dut.level_reg), 128 + 4 * (16 - k));
    end
    check("mute_active_low", int'(active_out), 0);
    for (int k = 1; k <= 16; k++) do_period(8'sd64, 1'b0, 3'd0);

    // Volume, rounding and extremes at full gain
    for (int i = 0; i < 8; i++) begin
      do_period(vecs[i].audio, 1'b0, vecs[i].vol);
      check($sformatf("vec%0d_level", i), int'(dut.level_reg), vecs[i].level);
      if (vecs[i].ones >= 0) begin
        count_ones(n);
        check($sformatf("vec%0d_ones", i), n, vecs[i].ones);
      end
    end

    // Reset in the middle of a ramp
    reset_dut();
    for (int k = 1; k <= 7; k++) do_period(8'sd64, 1'b0, 3'd0);
    check("pre_rst_gain", int'(dut.gain), 7);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("midrst_level", int'(dut.level_reg), 128);
    check("midrst_gain", int'(dut.gain), 0);
    check("midrst_acc", int'(dut.u_mod.acc), 0);
    check("midrst_pdm", int'(pdm_out), 0);
    check("midrst_active", int'(active_out), 0);
    reset_dut();
    do_period(8'sd64, 1'b0, 3'd0);
    check("restart_level", int'(dut.level_reg), 132);

    // Randomized periods against the reference model
    for (int i = 0; i < 150; i++) begin
      do_period(8'($urandom), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
    end
    exp_lvl = ref_level(msample, mgain, int'(volume_in));
    check("rand_final_level", int'(dut.level_reg), exp_lvl);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
